// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: display reads win,
// with a starvation limit so the processor still makes forward progress.
module dmem_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [1:0] rd_tag;
  logic       starved;
  logic       cpu_win;

  // The processor only overtakes a pending display read once starved.
  assign starved   = (wait_cnt == WAIT_LIM);
  assign cpu_win   = cpu_req & (~dsp_req | starved);
  assign cpu_gnt   = cpu_win;
  assign dsp_gnt   = dsp_req & ~cpu_win;
  assign cpu_stall = cpu_req & ~cpu_win;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_address = cpu_addr;
        mem_data    = cpu_wdata;
        mem_wren    = cpu_we;
      end
      dsp_gnt: begin
        mem_address = dsp_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      wait_cnt <= '0;
    end else if (dsp_gnt && !starved) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Tag remembers who owns the RAM output on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tag <= '0;
    end else begin
      rd_tag <= {dsp_gnt, cpu_gnt & ~cpu_we};
    end
  end

  assign cpu_rvalid = rd_tag[0];
  assign dsp_rvalid = rd_tag[1];
  assign cpu_rdata  = rd_tag[0] ? mem_q : '0;
  assign dsp_rdata  = rd_tag[1] ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dsp_req;
  logic [AW-1:0] dsp_addr;
  logic          dsp_gnt, dsp_rvalid;
  logic [DW-1:0] dsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid),
    .dsp_rdata(dsp_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Single-port RAM with registered read, small window of the space.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address[7:0]] <= mem_data;
    mem_q <= ram[mem_address[7:0]];
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic cycle(input logic cr, input logic cw,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic dr, input logic [AW-1:0] da);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dsp_req = dr; dsp_addr = da;
    #1;
  endtask

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          dr;
    logic [AW-1:0] da;
    logic          e_cg, e_dg, e_st, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vt [7];

  logic [DW-1:0] shadow [32];
  logic          cr, cw, dr;
  logic [AW-1:0] ca, da;
  logic [DW-1:0] cd;
  logic          mc, md, last_c, last_d;
  logic          ex_cv, ex_dv;
  logic [DW-1:0] ex_cd, ex_dd;
  int            waitc;

  initial begin
    vt[0] = '{0,0,0,0,        0,0,       0,0,0,0,0,0};
    vt[1] = '{1,1,19'h7FFFF,8'hFF, 0,0,   1,0,0,1,19'h7FFFF,8'hFF};
    vt[2] = '{1,0,19'h12345,8'h3C, 0,0,   1,0,0,0,19'h12345,8'h3C};
    vt[3] = '{0,0,0,0,        1,19'h54321, 0,1,0,0,19'h54321,0};
    vt[4] = '{1,1,19'h00077,8'h99, 1,19'h00ABC, 0,1,1,0,19'h00ABC,0};
    vt[5] = '{0,1,19'h00055,8'h66, 0,19'h00011, 0,0,0,0,0,0};
    vt[6] = '{0,1,19'h00055,8'h66, 1,19'h00022, 0,1,0,0,19'h00022,0};

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dsp_req = 0; dsp_addr = '0;
    #12;
    chk("reset_rvalid", 32'({cpu_rvalid, dsp_rvalid}), 32'(0));
    chk("reset_rdata", 32'({cpu_rdata, dsp_rdata}), 32'(0));
    chk("reset_bus", 32'({mem_wren, cpu_gnt, dsp_gnt}), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      cpu_req = vt[i].cr; cpu_we = vt[i].cw;
      cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      dsp_req = vt[i].dr; dsp_addr = vt[i].da;
      #1;
      rst = 1'b0;
      #1;
      chk($sformatf("vec%0d_gnt", i),
          32'({cpu_gnt, dsp_gnt, cpu_stall}),
          32'({vt[i].e_cg, vt[i].e_dg, vt[i].e_st}));
      chk($sformatf("vec%0d_wren", i), 32'(mem_wren), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_addr", i), 32'(mem_address),
          32'(vt[i].e_addr));
      chk($sformatf("vec%0d_data", i), 32'(mem_data), 32'(vt[i].e_data));
    end
    cycle(0, 0, 0, 0, 0, 0);

    // Processor write then read of the same location.
    cycle(1, 1, 19'h00010, 8'hA5, 0, 0);
    chk("cw_gnt", 32'({cpu_gnt, cpu_stall}), 32'(2));
    chk("cw_bus", 32'({mem_wren, mem_address, mem_data}),
        32'({1'b1, 19'h00010, 8'hA5}));
    cycle(1, 0, 19'h00010, 8'h00, 0, 0);
    chk("cr_gnt", 32'({cpu_gnt, mem_wren}), 32'(2));
    chk("cw_no_rvalid", 32'(cpu_rvalid), 32'(0));
    cycle(0, 0, 0, 0, 0, 0);
    chk("cr_rvalid", 32'(cpu_rvalid), 32'(1));
    chk("cr_rdata", 32'(cpu_rdata), 32'(8'hA5));
    chk("cr_no_dsp", 32'(dsp_rvalid), 32'(0));
    cycle(0, 0, 0, 0, 0, 0);
    chk("cr_rvalid_drop", 32'({cpu_rvalid, cpu_rdata}), 32'(0));

    for (int i = 0; i < 8; i++) cycle(1, 1, 19'(i), 8'(8'h10 + i), 0, 0);

    // Display streaming reads, one grant per cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, i < 8, 19'(i));
      chk($sformatf("dsp_gnt%0d", i), 32'(dsp_gnt), 32'(i < 8));
      chk($sformatf("dsp_rv%0d", i), 32'(dsp_rvalid),
          32'(i >= 1 && i <= 8));
      if (i >= 1 && i <= 8)
        chk($sformatf("dsp_rd%0d", i), 32'(dsp_rdata),
            32'(8'h10 + 8'(i - 1)));
    end

    // Display grant then processor grant, data must not cross.
    cycle(0, 0, 0, 0, 1, 19'd3);
    chk("il_dgnt", 32'({cpu_gnt, dsp_gnt}), 32'(1));
    cycle(1, 0, 19'h00010, 0, 0, 0);
    chk("il_cgnt", 32'({cpu_gnt, dsp_gnt}), 32'(2));
    chk("il_dsp", 32'({dsp_rvalid, dsp_rdata, cpu_rvalid}),
        32'({1'b1, 8'h13, 1'b0}));
    cycle(0, 0, 0, 0, 0, 0);
    chk("il_cpu", 32'({cpu_rvalid, cpu_rdata, dsp_rvalid, dsp_rdata}),
        32'({1'b1, 8'hA5, 1'b0, 8'h00}));

    // Build up wait count, then reset with a display read in flight.
    cycle(1, 0, 19'h00010, 0, 1, 19'd5);
    cycle(1, 0, 19'h00010, 0, 1, 19'd5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_rv", 32'({dsp_rvalid, cpu_rvalid}), 32'(0));
    chk("rst_mid_rd", 32'(dsp_rdata), 32'(0));
    chk("rst_comb_gnt", 32'({cpu_gnt, dsp_gnt}), 32'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 0; dsp_req = 0;
    #1;
    chk("rst_after_rv", 32'({dsp_rvalid, cpu_rvalid}), 32'(0));

    // Contention: wait count restarts at zero after reset.
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 19'h00010, 0, 1, 19'd6);
      chk($sformatf("ct_cgnt%0d", k), 32'(cpu_gnt), 32'(k % 5 == 4));
      chk($sformatf("ct_dgnt%0d", k), 32'(dsp_gnt), 32'(k % 5 != 4));
      chk($sformatf("ct_stall%0d", k), 32'(cpu_stall), 32'(k % 5 != 4));
      chk($sformatf("ct_rv%0d", k), 32'({cpu_rvalid, dsp_rvalid}),
          32'({k > 0 && k % 5 == 0, k > 0 && k % 5 != 0}));
    end

    cycle(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk($sformatf("idle%0d", k),
          32'({mem_wren, mem_address, cpu_gnt, dsp_gnt,
               cpu_rvalid, dsp_rvalid}), 32'(0));
    end

    // Randomized run against a transaction-level model.
    for (int i = 0; i < 32; i++) begin
      shadow[i] = 8'(i * 7 + 3);
      cycle(1, 1, 19'(i), shadow[i], 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0);
    waitc = 0;
    cr = 0; dr = 0; cw = 0; ca = '0; da = '0; cd = '0;
    last_c = 0; last_d = 0;
    ex_cv = 0; ex_dv = 0; ex_cd = '0; ex_dd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!cr || last_c) begin
        cr = ($urandom_range(0, 1) == 1);
        cw = ($urandom_range(0, 2) == 0);
        ca = 19'($urandom_range(0, 31));
        cd = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        cr = 0;
      end
      if (!dr || last_d) begin
        dr = ($urandom_range(0, 3) != 0);
        da = 19'($urandom_range(0, 31));
      end else if ($urandom_range(0, 15) == 0) begin
        dr = 0;
      end
      cycle(cr, cw, ca, cd, dr, da);
      mc = cr && (!dr || waitc == MW);
      md = dr && !mc;
      chk("rnd_gnt", 32'({cpu_gnt, dsp_gnt, cpu_stall}),
          32'({mc, md, cr && !mc}));
      chk("rnd_bus", 32'({mem_wren, mem_address, mem_data}),
          mc ? 32'({cw, ca, cd}) : md ? 32'({1'b0, da, 8'h00}) : 32'(0));
      chk("rnd_cpu_rv", 32'({cpu_rvalid, cpu_rdata}),
          32'({ex_cv, ex_cv ? ex_cd : 8'h00}));
      chk("rnd_dsp_rv", 32'({dsp_rvalid, dsp_rdata}),
          32'({ex_dv, ex_dv ? ex_dd : 8'h00}));
      ex_cv = mc && !cw;
      ex_cd = shadow[ca[4:0]];
      ex_dv = md;
      ex_dd = shadow[da[4:0]];
      if (mc && cw) shadow[ca[4:0]] = cd;
      if (!cr || mc) waitc = 0;
      else if (md) waitc = waitc + 1;
      last_c = mc;
      last_d = md;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
